// File: rtl/seq1010_stream_ctrl.sv
// Word-to-bit stream controller feeding an overlapping "1010" Mealy detector,
// with a saturating match counter and a sticky threshold interrupt.
module seq1010_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] thresh,
    input  logic             clr,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             irq
);

    localparam int BC_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [1:0] D_S0   = 2'd0;
    localparam logic [1:0] D_S1   = 2'd1;
    localparam logic [1:0] D_S10  = 2'd2;
    localparam logic [1:0] D_S101 = 2'd3;

    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state_q,  state_d;
    logic [1:0]       det_q,    det_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic             pulse_q,  pulse_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             irq_q,    irq_d;

    logic shifting;
    logic last_bit;
    logic accept;
    logic scan_bit;
    logic match_comb;

    function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
        logic [1:0] n;
        n = D_S0;
        case (s)
            D_S0:    n = b ? D_S1   : D_S0;
            D_S1:    n = b ? D_S1   : D_S10;
            D_S10:   n = b ? D_S101 : D_S0;
            D_S101:  n = b ? D_S1   : D_S10;
            default: n = D_S0;
        endcase
        return n;
    endfunction

    assign shifting   = (state_q == ST_SHIFT);
    assign last_bit   = shifting && (bitcnt_q == '0);
    // Ready on the last shift cycle too, so words stream with no bubble.
    assign in_ready   = !clr && ((state_q == ST_IDLE) || last_bit);
    assign accept     = in_valid && in_ready;
    assign scan_bit   = shreg_q[WIDTH-1];
    assign match_comb = shifting && (det_q == D_S101) && !scan_bit;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (clr) begin
            state_d  = ST_IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
        end else if (accept) begin
            state_d  = ST_SHIFT;
            shreg_d  = in_data;
            bitcnt_d = BC_LAST;
        end else if (shifting) begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            bitcnt_d = bitcnt_q - 1'b1;
            if (last_bit) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Detector state is kept across words and idle gaps; only clr restarts it.
    always_comb begin
        det_d = det_q;
        if (clr) begin
            det_d = D_S0;
        end else if (shifting) begin
            det_d = det_next(det_q, scan_bit);
        end
    end

    always_comb begin
        pulse_d = 1'b0;
        count_d = count_q;
        irq_d   = irq_q;
        if (clr) begin
            count_d = '0;
            irq_d   = 1'b0;
        end else if (match_comb) begin
            pulse_d = 1'b1;
            // irq only fires on the increment that lands on thresh.
            if (count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
                if ((thresh != '0) && (count_d == thresh)) begin
                    irq_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            det_q    <= D_S0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            det_q    <= det_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    assign busy        = shifting;
    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_seq1010_stream_ctrl.sv
// Bench for seq1010_stream_ctrl: reference vectors, directed corner sequences
// and random traffic checked against a bit-stream reference model.
module tb_seq1010_stream_ctrl;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] thresh;
    logic       clr;
    logic       busy;
    logic       match_pulse;
    logic [7:0] match_count;
    logic       irq;

    seq1010_stream_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .thresh     (thresh),
        .clr        (clr),
        .busy       (busy),
        .match_pulse(match_pulse),
        .match_count(match_count),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic [7:0] th;
        logic       rdy;
        logic       bsy;
        logic       pls;
        logic [7:0] cnt;
        logic       irq;
    } vec_t;

    vec_t tbl[13];
    vec_t nil;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int npulse      = 0;
    int last_pulse  = -1;
    bit samp_rdy;

    // Reference model: the queue holds bits still to be scanned; a match is the
    // scanned history (since reset/clr) ending in 1010.
    bit       pend[$];
    bit [3:0] hist;
    int       hlen;
    int       m_cnt;
    bit       m_irq;
    bit       m_pls;

    function automatic void model_reset();
        pend.delete();
        hist  = 4'b0000;
        hlen  = 0;
        m_cnt = 0;
        m_irq = 1'b0;
        m_pls = 1'b0;
    endfunction

    function automatic void model_step(logic v, logic [7:0] d, logic c, logic [7:0] th);
        bit rdy;
        bit b;
        rdy = !c && (pend.size() <= 1);
        if (c) begin
            model_reset();
            return;
        end
        m_pls = 1'b0;
        if (pend.size() != 0) begin
            b    = pend.pop_front();
            hist = {hist[2:0], b};
            if (hlen < 4) hlen++;
            if (hlen == 4 && hist == 4'b1010) begin
                m_pls = 1'b1;
                if (m_cnt < 255) begin
                    m_cnt++;
                    if (th != 8'd0 && m_cnt == int'(th)) m_irq = 1'b1;
                end
            end
        end
        if (v && rdy) begin
            for (int i = 7; i >= 0; i--) pend.push_back(d[i]);
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at a falling edge; drives inputs, checks outputs, crosses one rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c,
                        input logic [7:0] th, input bit use_tbl, input vec_t e);
        in_valid = v;
        in_data  = d;
        clr      = c;
        thresh   = th;
        #1;
        if (use_tbl) begin
            chk("tbl_in_ready", in_ready, e.rdy);
            chk("tbl_busy", busy, e.bsy);
            chk("tbl_match_pulse", match_pulse, e.pls);
            chk("tbl_match_count", match_count, e.cnt);
            chk("tbl_irq", irq, e.irq);
        end else begin
            chk("in_ready", in_ready, (!c && pend.size() <= 1) ? 1 : 0);
            chk("busy", busy, (pend.size() != 0) ? 1 : 0);
            chk("match_pulse", match_pulse, m_pls);
            chk("match_count", match_count, m_cnt);
            chk("irq", irq, m_irq);
        end
        samp_rdy = in_ready;
        if (match_pulse) begin
            npulse++;
            last_pulse = cyc;
        end
        @(posedge clk);
        model_step(v, d, c, th);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic [7:0] th);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, th, 1'b0, nil);
    endtask

    task automatic send_word(input logic [7:0] d, input logic [7:0] th);
        int g;
        bit done;
        g    = 0;
        done = 1'b0;
        while (!done && g < 64) begin
            step(1'b1, d, 1'b0, th, 1'b0, nil);
            done = samp_rdy;
            g++;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic reset_outputs_chk(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_match_pulse"}, match_pulse, 0);
        chk({tag, "_match_count"}, match_count, 0);
        chk({tag, "_irq"}, irq, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [7:0] rth;
        logic [7:0] rd;
        logic       rv;
        logic       rc;

        tbl[0]  = '{1'b1, 8'hAA, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
        nil     = tbl[0];

        clk_en   = 1'b0;
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        thresh   = 8'd0;
        model_reset();
        #3;
        reset_outputs_chk("por");
        rst = 1'b0;
        #2;
        clk_en = 1'b1;
        @(negedge clk);

        // 8'hAA with thresh=2, then clr, against hand-derived vectors
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].th, 1'b1, tbl[i]);
        end

        // thresh=0 never raises irq
        npulse = 0;
        send_word(8'hAA, 8'd0);
        idle(10, 8'd0);
        chk("thr0_irq", irq, 0);
        chk("thr0_count", match_count, 3);
        chk("thr0_pulses", npulse, 3);

        // pattern spanning a word boundary
        step(1'b0, 8'h00, 1'b1, 8'd0, 1'b0, nil);
        npulse = 0;
        send_word(8'h05, 8'd0);
        t0 = cyc - 1;
        send_word(8'h00, 8'd0);
        idle(10, 8'd0);
        chk("xb_pulses", npulse, 1);
        chk("xb_pulse_cycle", last_pulse, t0 + 10);
        chk("xb_count", match_count, 1);

        // clr during the third shift cycle
        step(1'b0, 8'h00, 1'b1, 8'd2, 1'b0, nil);
        send_word(8'hAA, 8'd2);
        step(1'b0, 8'h00, 1'b0, 8'd2, 1'b0, nil);
        step(1'b0, 8'h00, 1'b0, 8'd2, 1'b0, nil);
        step(1'b0, 8'h00, 1'b1, 8'd2, 1'b0, nil);
        clr = 1'b0;
        #1;
        chk("clr_count", match_count, 0);
        chk("clr_irq", irq, 0);
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", in_ready, 1);
        send_word(8'h0A, 8'd2);
        idle(10, 8'd2);
        chk("clr_0a_count", match_count, 1);

        // saturation over 65 back-to-back words
        step(1'b0, 8'h00, 1'b1, 8'd0, 1'b0, nil);
        npulse = 0;
        for (int w = 0; w < 65; w++) send_word(8'hAA, 8'd0);
        idle(10, 8'd0);
        chk("sat_count", match_count, 255);
        chk("sat_pulses", npulse, 259);

        // asynchronous reset mid-word
        step(1'b0, 8'h00, 1'b1, 8'd1, 1'b0, nil);
        send_word(8'hAA, 8'd1);
        idle(5, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        reset_outputs_chk("mid_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;

        // random traffic
        rth = 8'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rth = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
            end
            rv = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            rc = ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0;
            step(rv, rd, rc, rth, 1'b0, nil);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq1010_stream_ctrl.md
# seq1010_stream_ctrl

Word-level controller for the overlapping "1010" Mealy sequence detector. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into an embedded overlapping 1010 Mealy detector. It counts detections with a saturating counter and raises a sticky interrupt at a programmable threshold. It sits between a word-oriented producer and the serial detection datapath, so software and upstream logic never drive bit timing.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- CNT_W, 8, match counter and threshold width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  word to scan, MSB shifted first
- in_valid  input  1  in_data valid
- in_ready  output  1  controller can accept a word this cycle
- thresh  input  CNT_W  irq threshold; 0 disables irq
- clr  input  1  synchronous clear of count, irq, detector and control FSM
- busy  output  1  word being shifted
- match_pulse  output  1  one-cycle registered pulse per detected 1010
- match_count  output  CNT_W  saturating number of matches since reset/clr
- irq  output  1  sticky, set when match_count reaches thresh

## Operation
- Reset: all outputs 0 except in_ready=1. Control FSM in IDLE, detector in S0, shift register and bit counter 0.
- Control FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load shift register with in_data, load bit counter with WIDTH-1, and go to SHIFT.
  - SHIFT: each cycle, present the shift register MSB to the detector, shift left, and decrement the bit counter. At bit counter 0 (last bit), go to IDLE, or reload and stay in SHIFT if a new word is accepted that cycle.
- in_ready = !clr & (IDLE | (SHIFT & bitcnt==0)). This gives back-to-back words with no bubble, one word per WIDTH cycles.
- busy = (state==SHIFT).
- Detector states: S0 (nothing), S1 ("1"), S10 ("10"), S101 ("101"). It advances only in SHIFT cycles.
  - S0: 1→S1, 0→S0.
  - S1: 1→S1, 0→S10.
  - S10: 1→S101, 0→S0.
  - S101: 1→S1, 0→S10 with match.
- Overlapping detection: a match leaves the detector in S10.
- Detector state persists across word boundaries and idle gaps, so patterns spanning two words are detected.
- match_comb = SHIFT & S101 & bit==0.
  - match_pulse is match_comb registered.
  - match_count increments by 1 on match_comb and saturates at 2^CNT_W-1.
- irq: sets when an increment makes the count equal thresh. It stays set until clr or rst and is never set when thresh==0.
  - Changing thresh to a value at or below the current count does not set irq.
- clr has priority over everything. The next state is match_count=0, irq=0, match_pulse=0, detector S0, FSM IDLE.
  - A word in flight is discarded.
  - No word is accepted during the clr cycle.
- A match arriving in the same cycle as clr is dropped.
- Reset asserted mid-word forces all outputs to their reset values immediately, without waiting for a clock edge.

## Timing
- Word accepted at edge of cycle T: MSB is scanned in cycle T+1, LSB in cycle T+WIDTH.
- A match on the bit scanned in cycle k produces match_pulse high in cycle k+1. match_count and irq update in k+1.
- Back-to-back accept at cycle T+WIDTH: next word's MSB is scanned in T+WIDTH+1.
- clr asserted in cycle c: in_ready=0 in c. Cleared state and in_ready=1 appear from c+1.
- in_valid with in_ready=0 is ignored. The producer holds in_data until accepted.

## Test plan
- Reset: assert rst with no clock, then release → in_ready=1, busy=0, match_count=0, irq=0, match_pulse=0. Assert rst mid-word → outputs return to these values before the next edge.
- Single word 8'hAA accepted at T → match_pulse high in cycles T+5, T+7 and T+9, match_count=3, busy low from T+9.
- Cross-boundary: 8'h05 then 8'h00 back-to-back from reset → exactly one match_pulse, in the cycle after the second word's MSB is scanned (T+10), match_count=1.
- Threshold: thresh=2, word 8'hAA → irq rises with the second pulse (T+7) and stays high. match_count ends at 3. thresh=0 on the same stimulus → irq stays 0.
- Saturation: 65 back-to-back 8'hAA words → count is 3 after word 1, increases by 4 per subsequent word, and holds 255 after word 64 and through word 65. match_pulse still fires.
- Clear mid-word: clr in the third SHIFT cycle of 8'hAA → count=0, irq=0, busy=0, in_ready=1 next cycle. Then 8'h0A → match_count=1.
